// File: rtl/serial_full_subtractor_if.sv
// Bundles the operand/command and result/status signals of the bit-serial
// subtractor so the datapath and its driver share one connection.
//   start, a_in, b_in, borrow_in : command and operands (master -> slave)
//   busy, done                   : RUN indicator, one-cycle completion pulse
//   diff, borrow_out, overflow   : parallel result, held until next completion
//   diff_bit, diff_bit_valid     : serial result stream, LSB first
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             diff_bit;
    logic             diff_bit_valid;

    modport master (
        output start, a_in, b_in, borrow_in,
        input  busy, done, diff, borrow_out, overflow, diff_bit, diff_bit_valid
    );

    modport slave (
        input  start, a_in, b_in, borrow_in,
        output busy, done, diff, borrow_out, overflow, diff_bit, diff_bit_valid
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per cycle, LSB first.
// A single full-subtractor cell works on the operand LSBs while a registered
// borrow carries between bits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_full_subtractor_if slave (command, operands, results)
//
// state | meaning
// IDLE  | waiting for start; result outputs hold last completed value
// RUN   | WIDTH cycles, one result bit per cycle
// DONE  | one cycle, done pulse with the parallel result
module serial_full_subtractor #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_full_subtractor_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;

    logic             w_d;
    logic             w_bnext;
    logic             w_last;

    // Full-subtractor cell on the current LSBs.
    assign w_d     = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_bnext = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_res        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a_sr <= bus.a_in;
                        r_b_sr <= bus.b_in;
                        r_br   <= bus.borrow_in;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_res  <= {w_d, r_res[WIDTH-1:1]};
                    r_br   <= w_bnext;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Public result updates only here, so diff stays
                        // stable while the next operation is computing.
                        r_diff       <= {w_d, r_res[WIDTH-1:1]};
                        r_borrow_out <= w_bnext;
                        // r_br is the borrow into the MSB at this point.
                        r_overflow   <= r_br ^ w_bnext;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode the registered state, so reset clears them at once.
    assign bus.busy           = (r_state == RUN);
    assign bus.done           = (r_state == DONE);
    assign bus.diff_bit_valid = (r_state == RUN);
    assign bus.diff_bit       = (r_state == RUN) ? w_d : 1'b0;
    assign bus.diff           = r_diff;
    assign bus.borrow_out     = r_borrow_out;
    assign bus.overflow       = r_overflow;

endmodule
